pm_event_capture: RTL and testbench

Firmware-side receiver for the power-monitor output signals (warn, fault, eoc, pgood bus). It synchronizes these inputs into its own clock domain and debounces the pgood vector. It captures edges into sticky status bits and per-converter loss flags, and raises an interrupt for the CPU status/clear register interface. It sits between the power-monitor outputs and the CPU status registers.

---
 rtl/pm_event_capture_if.sv | 22 ++
 rtl/pm_event_capture.sv | 173 +++++++++++++++++
 tb/tb_pm_event_capture.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pm_event_capture_if.sv
// CPU-side register bundle of the power-monitor event capture block:
// clear/enable controls from the CPU and the captured status toward it.
interface pm_event_capture_if;
    logic        clear_strobe;
    logic [7:0]  clear_mask;
    logic [7:0]  irq_mask;
    logic [7:0]  status;
    logic [31:0] pgood_filtered;
    logic [31:0] pgood_lost;
    logic [7:0]  eoc_count;
    logic        irq;

    modport master (
        output clear_strobe, clear_mask, irq_mask,
        input  status, pgood_filtered, pgood_lost, eoc_count, irq
    );

    modport slave (
        input  clear_strobe, clear_mask, irq_mask,
        output status, pgood_filtered, pgood_lost, eoc_count, irq
    );
endinterface

// File: rtl/pm_event_capture.sv
// Firmware-side receiver for the power-monitor outputs. Brings warn, fault,
// eoc and the pgood vector into the local clock domain, debounces pgood,
// records edges as sticky status bits / per-converter loss flags, and
// raises an interrupt toward the CPU status/clear registers.
module pm_event_capture #(
    parameter int NumConverters  = 8,
    parameter int DebounceCycles = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              warn_in,
    input  logic              fault_in,
    input  logic              eoc_in,
    input  logic [31:0]       pgood_in,
    pm_event_capture_if.slave cpu
);

    localparam logic [31:0] PgoodMask =
        (NumConverters >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NumConverters) - 32'd1);
    localparam logic [7:0] DebounceTarget = 8'(DebounceCycles);

    typedef enum logic {
        IDLE,
        QUAL
    } deb_state_t;

    deb_state_t  state, state_next;

    logic        warn_s1, warn_s2, warn_prev;
    logic        fault_s1, fault_s2, fault_prev;
    logic        eoc_s1, eoc_s2, eoc_prev;
    logic [31:0] pgood_s1, pgood_s2;

    logic [31:0] cand, cand_next;
    logic [7:0]  cnt, cnt_next;
    logic        filt_update;

    logic [31:0] filt_q;
    logic [31:0] lost_q, lost_next;
    logic [7:0]  status_q, status_next;
    logic [7:0]  count_q, count_next, count_base;
    logic        irq_q, irq_next;

    logic [5:0]  clr;
    logic [5:0]  set_bits;
    logic        warn_rise, fault_rise, eoc_rise;
    logic [31:0] pgood_fell, pgood_rose;
    logic        unused_clear_bits;

    // Two-flop synchronizers plus an edge-detect history flop per input;
    // pgood bits beyond the converter count are forced to 0 on entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            warn_s1    <= 1'b0;
            warn_s2    <= 1'b0;
            warn_prev  <= 1'b0;
            fault_s1   <= 1'b0;
            fault_s2   <= 1'b0;
            fault_prev <= 1'b0;
            eoc_s1     <= 1'b0;
            eoc_s2     <= 1'b0;
            eoc_prev   <= 1'b0;
            pgood_s1   <= 32'd0;
            pgood_s2   <= 32'd0;
        end else begin
            warn_s1    <= warn_in;
            warn_s2    <= warn_s1;
            warn_prev  <= warn_s2;
            fault_s1   <= fault_in;
            fault_s2   <= fault_s1;
            fault_prev <= fault_s2;
            eoc_s1     <= eoc_in;
            eoc_s2     <= eoc_s1;
            eoc_prev   <= eoc_s2;
            pgood_s1   <= pgood_in & PgoodMask;
            pgood_s2   <= pgood_s1;
        end
    end

    // Debounce state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Debounce decisions: qualify a new pgood candidate for DebounceCycles
    // consecutive cycles, abandon on return to the filtered value, restart
    // on any other change.
    always_comb begin
        state_next  = state;
        cand_next   = cand;
        cnt_next    = cnt;
        filt_update = 1'b0;
        case (state)
            IDLE: begin
                if (pgood_s2 != filt_q) begin
                    cand_next  = pgood_s2;
                    cnt_next   = 8'd1;
                    state_next = QUAL;
                end
            end
            QUAL: begin
                if (pgood_s2 == cand) begin
                    if (cnt == DebounceTarget) begin
                        filt_update = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        cnt_next = cnt + 8'd1;
                    end
                end else if (pgood_s2 == filt_q) begin
                    state_next = IDLE;
                end else begin
                    cand_next = pgood_s2;
                    cnt_next  = 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Event detection and next values for the sticky status, loss flags,
    // eoc counter and interrupt; a set in the same cycle as a clear wins.
    always_comb begin
        clr        = cpu.clear_strobe ? cpu.clear_mask[5:0] : 6'd0;
        warn_rise  = warn_s2 & ~warn_prev;
        fault_rise = fault_s2 & ~fault_prev;
        eoc_rise   = eoc_s2 & ~eoc_prev;
        pgood_fell = filt_update ? (filt_q & ~cand) : 32'd0;
        pgood_rose = filt_update ? (cand & ~filt_q) : 32'd0;
        set_bits   = {eoc_rise & status_q[2], |pgood_rose, |pgood_fell,
                      eoc_rise, fault_rise, warn_rise};
        status_next = {1'b0, fault_s2, (status_q[5:0] & ~clr) | set_bits};
        lost_next   = (lost_q & ~{32{clr[3]}}) | pgood_fell;
        count_base  = clr[2] ? 8'd0 : count_q;
        count_next  = (eoc_rise && (count_base != 8'hFF)) ? count_base + 8'd1 : count_base;
        irq_next    = |(status_q & cpu.irq_mask);
    end

    // Debounce datapath and all CPU-visible registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cand     <= 32'd0;
            cnt      <= 8'd0;
            filt_q   <= 32'd0;
            lost_q   <= 32'd0;
            status_q <= 8'd0;
            count_q  <= 8'd0;
            irq_q    <= 1'b0;
        end else begin
            cand     <= cand_next;
            cnt      <= cnt_next;
            if (filt_update) begin
                filt_q <= cand;
            end
            lost_q   <= lost_next;
            status_q <= status_next;
            count_q  <= count_next;
            irq_q    <= irq_next;
        end
    end

    assign unused_clear_bits  = ^cpu.clear_mask[7:6];

    assign cpu.status         = status_q;
    assign cpu.pgood_filtered = filt_q;
    assign cpu.pgood_lost     = lost_q;
    assign cpu.eoc_count      = count_q;
    assign cpu.irq            = irq_q;

endmodule

// File: tb/tb_pm_event_capture.sv
// Directed bench for pm_event_capture: expected values are queued as each
// stimulus step is applied and popped in order as the outputs are sampled.
module tb_pm_event_capture;

    logic        clock;
    logic        reset_n;
    logic        warn;
    logic        fault;
    logic        eoc;
    logic [31:0] pgood;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t expQueue[$];

    pm_event_capture_if cpu ();

    pm_event_capture #(
        .NumConverters (8),
        .DebounceCycles(4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .warn_in (warn),
        .fault_in(fault),
        .eoc_in  (eoc),
        .pgood_in(pgood),
        .cpu     (cpu.slave)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic w, input logic f, input logic e,
                                 input logic [31:0] pg);
        warn  = w;
        fault = f;
        eoc   = e;
        pgood = pg;
    endtask

    task automatic setCpu(input logic strobe, input logic [7:0] cmask,
                          input logic [7:0] imask);
        cpu.clear_strobe = strobe;
        cpu.clear_mask   = cmask;
        cpu.irq_mask     = imask;
    endtask

    task automatic expectValue(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        expQueue.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] actual);
        exp_t e;
        total++;
        if (expQueue.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty observed=0x%0h expected=<none>", actual);
            return;
        end
        e = expQueue.pop_front();
        assert (actual === e.value) else begin
            bad++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", e.tag, actual, e.value);
            $error("[TB] check %s did not match", e.tag);
        end
    endtask

    task automatic pulseEoc();
        applyStimulus(warn, fault, 1'b1, pgood);
        tick(1);
        applyStimulus(warn, fault, 1'b0, pgood);
        tick(1);
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        setCpu(1'b0, 8'h00, 8'h00);
        tick(3);

        $display("[TB] reset state");
        expectValue("rst_status", 32'h00);
        expectValue("rst_filtered", 32'h00);
        expectValue("rst_lost", 32'h00);
        expectValue("rst_count", 32'h00);
        expectValue("rst_irq", 32'h0);
        checkOutput({24'd0, cpu.status});
        checkOutput(cpu.pgood_filtered);
        checkOutput(cpu.pgood_lost);
        checkOutput({24'd0, cpu.eoc_count});
        checkOutput({31'd0, cpu.irq});
        reset_n = 1'b1;
        tick(2);

        $display("[TB] warn edge latency, irq and clear");
        setCpu(1'b0, 8'h00, 8'h01);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        expectValue("warn_status_k1", 32'h00);
        expectValue("warn_status_k2", 32'h01);
        expectValue("warn_irq_k2", 32'h0);
        expectValue("warn_irq_k3", 32'h1);
        tick(2);
        checkOutput({24'd0, cpu.status});
        tick(1);
        checkOutput({24'd0, cpu.status});
        checkOutput({31'd0, cpu.irq});
        tick(1);
        checkOutput({31'd0, cpu.irq});
        setCpu(1'b1, 8'h01, 8'h01);
        expectValue("warn_clear_status", 32'h00);
        expectValue("warn_clear_irq", 32'h0);
        tick(1);
        setCpu(1'b0, 8'h00, 8'h01);
        checkOutput({24'd0, cpu.status});
        tick(1);
        checkOutput({31'd0, cpu.irq});
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        tick(3);

        $display("[TB] pgood rise debounce");
        setCpu(1'b0, 8'h00, 8'h10);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_00FF);
        expectValue("rise_filtered_early", 32'h00);
        expectValue("rise_filtered", 32'hFF);
        expectValue("rise_status", 32'h10);
        expectValue("rise_irq", 32'h1);
        tick(6);
        checkOutput(cpu.pgood_filtered);
        tick(1);
        checkOutput(cpu.pgood_filtered);
        checkOutput({24'd0, cpu.status});
        tick(1);
        checkOutput({31'd0, cpu.irq});

        $display("[TB] pgood glitch is rejected");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_00F7);
        tick(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_00FF);
        expectValue("glitch_filtered", 32'hFF);
        expectValue("glitch_status", 32'h10);
        expectValue("glitch_lost", 32'h00);
        tick(10);
        checkOutput(cpu.pgood_filtered);
        checkOutput({24'd0, cpu.status});
        checkOutput(cpu.pgood_lost);

        $display("[TB] pgood fall and loss flag");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_00F7);
        expectValue("fall_filtered_early", 32'hFF);
        expectValue("fall_filtered", 32'hF7);
        expectValue("fall_lost", 32'h08);
        expectValue("fall_status", 32'h18);
        tick(6);
        checkOutput(cpu.pgood_filtered);
        tick(1);
        checkOutput(cpu.pgood_filtered);
        checkOutput(cpu.pgood_lost);
        checkOutput({24'd0, cpu.status});
        setCpu(1'b1, 8'h18, 8'h10);
        expectValue("fall_clear_status", 32'h00);
        expectValue("fall_clear_lost", 32'h00);
        expectValue("fall_clear_irq", 32'h0);
        tick(1);
        setCpu(1'b0, 8'h00, 8'h10);
        checkOutput({24'd0, cpu.status});
        checkOutput(cpu.pgood_lost);
        tick(1);
        checkOutput({31'd0, cpu.irq});

        $display("[TB] pgood bit above converter count ignored");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_10F7);
        expectValue("masked_filtered", 32'hF7);
        expectValue("masked_status", 32'h00);
        tick(12);
        checkOutput(cpu.pgood_filtered);
        checkOutput({24'd0, cpu.status});

        $display("[TB] eoc count, overrun and saturation");
        setCpu(1'b0, 8'h00, 8'h00);
        expectValue("eoc3_count", 32'd3);
        expectValue("eoc3_status", 32'h24);
        for (int i = 0; i < 3; i++) pulseEoc();
        tick(3);
        checkOutput({24'd0, cpu.eoc_count});
        checkOutput({24'd0, cpu.status});
        expectValue("eoc_sat_count", 32'd255);
        for (int i = 0; i < 300; i++) pulseEoc();
        tick(3);
        checkOutput({24'd0, cpu.eoc_count});
        setCpu(1'b1, 8'h24, 8'h00);
        expectValue("eoc_clear_count", 32'd0);
        expectValue("eoc_clear_status", 32'h00);
        tick(1);
        setCpu(1'b0, 8'h00, 8'h00);
        checkOutput({24'd0, cpu.eoc_count});
        checkOutput({24'd0, cpu.status});

        $display("[TB] clear and eoc edge in the same cycle");
        expectValue("eoc1_count", 32'd1);
        expectValue("eoc1_status", 32'h04);
        pulseEoc();
        tick(3);
        checkOutput({24'd0, cpu.eoc_count});
        checkOutput({24'd0, cpu.status});
        applyStimulus(1'b0, 1'b0, 1'b1, pgood);
        tick(2);
        setCpu(1'b1, 8'h04, 8'h00);
        expectValue("setwins_status2", 32'h04);
        expectValue("setwins_count", 32'd1);
        tick(1);
        setCpu(1'b0, 8'h00, 8'h00);
        checkOutput({24'd0, cpu.status & 8'h04});
        checkOutput({24'd0, cpu.eoc_count});
        applyStimulus(1'b0, 1'b0, 1'b0, pgood);
        tick(3);

        $display("[TB] fault edge and live fault level");
        setCpu(1'b1, 8'hFF, 8'h40);
        tick(1);
        setCpu(1'b0, 8'h00, 8'h40);
        applyStimulus(1'b0, 1'b1, 1'b0, pgood);
        expectValue("fault_status_k1", 32'h00);
        expectValue("fault_status_k2", 32'h42);
        expectValue("fault_irq", 32'h1);
        tick(2);
        checkOutput({24'd0, cpu.status});
        tick(1);
        checkOutput({24'd0, cpu.status});
        tick(1);
        checkOutput({31'd0, cpu.irq});
        setCpu(1'b1, 8'hFF, 8'h40);
        expectValue("fault_level_not_cleared", 32'h40);
        tick(1);
        setCpu(1'b0, 8'h00, 8'h40);
        checkOutput({24'd0, cpu.status});
        applyStimulus(1'b0, 1'b0, 1'b0, pgood);
        expectValue("fault_level_drop", 32'h00);
        tick(3);
        checkOutput({24'd0, cpu.status});

        $display("[TB] reset during qualification");
        setCpu(1'b0, 8'h00, 8'h10);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_00FF);
        tick(3);
        reset_n = 1'b0;
        #1;
        expectValue("midrst_status", 32'h00);
        expectValue("midrst_filtered", 32'h00);
        expectValue("midrst_lost", 32'h00);
        expectValue("midrst_count", 32'h00);
        expectValue("midrst_irq", 32'h0);
        checkOutput({24'd0, cpu.status});
        checkOutput(cpu.pgood_filtered);
        checkOutput(cpu.pgood_lost);
        checkOutput({24'd0, cpu.eoc_count});
        checkOutput({31'd0, cpu.irq});
        tick(2);
        reset_n = 1'b1;
        expectValue("requal_filtered_early", 32'h00);
        expectValue("requal_filtered", 32'hFF);
        expectValue("requal_status", 32'h10);
        expectValue("requal_irq", 32'h1);
        tick(6);
        checkOutput(cpu.pgood_filtered);
        tick(1);
        checkOutput(cpu.pgood_filtered);
        checkOutput({24'd0, cpu.status});
        tick(1);
        checkOutput({31'd0, cpu.irq});

        if (expQueue.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", expQueue.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
